// File: rtl/kvs_pkg.sv
// Shared types and constants for the KVS kernel command arbiter.
package kvs_pkg;

    localparam int KEY_W  = 128;
    localparam int VAL_W  = 32;
    localparam int ADDR_W = 16;

    typedef enum logic [2:0] {
        CMD_NOP    = 3'd0,
        CMD_SEARCH = 3'd1,
        CMD_UPDATE = 3'd2,
        CMD_WRITE  = 3'd3,
        CMD_ERASE  = 3'd4,
        CMD_READ   = 3'd5
    } kvs_cmd_t;

    typedef enum logic [2:0] {
        ST_WAIT_RDY,
        ST_INIT,
        ST_INIT_WAIT,
        ST_RUN,
        ST_DRAIN
    } arb_state_t;

    // Strobe vector order: {valid, search, update, write, erase, read}
    function automatic logic [5:0] cmd_strobes(input logic [2:0] cmd);
        logic [5:0] s;
        s = 6'b000000;
        case (cmd)
            CMD_SEARCH: s = 6'b110000;
            CMD_UPDATE: s = 6'b101000;
            CMD_WRITE:  s = 6'b100100;
            CMD_ERASE:  s = 6'b100010;
            CMD_READ:   s = 6'b100001;
            default:    s = 6'b000000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/kvs_cmd_arbiter_tag_fifo.sv
// Synchronous FIFO of requester tags, one entry per command awaiting O_ACK.
module kvs_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 1
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [TAG_W-1:0]         push_tag,
    input  logic                     pop,
    output logic [TAG_W-1:0]         pop_tag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (count_reg != (AW+1)'(DEPTH));
    assign pop_ok  = pop && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head is read combinationally so the tag is known in the O_ACK cycle.
    assign pop_tag = mem[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/kvs_cmd_arbiter.sv
// Round-robin sharing of the axonerve_kvs_kernel command port, with kernel
// init sequencing and in-order routing of O_ACK responses to requesters.
module kvs_cmd_arbiter
    import kvs_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    output logic                     ready,
    output logic                     error,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*3-1:0]     req_cmd,
    input  logic [NUM_REQ*KEY_W-1:0] req_key,
    input  logic [NUM_REQ*VAL_W-1:0] req_value,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic                     rsp_hit,
    output logic                     rsp_multi,
    output logic                     rsp_err,
    output logic [VAL_W-1:0]         rsp_value,
    output logic [ADDR_W-1:0]        rsp_addr,
    output logic                     I_CMD_INIT,
    output logic                     I_CMD_VALID,
    output logic                     I_CMD_ERASE,
    output logic                     I_CMD_WRITE,
    output logic                     I_CMD_READ,
    output logic                     I_CMD_SEARCH,
    output logic                     I_CMD_UPDATE,
    output logic [KEY_W-1:0]         I_KEY_DAT,
    output logic [VAL_W-1:0]         I_KEY_VALUE,
    output logic [KEY_W-1:0]         I_EKEY_MSK,
    output logic [6:0]               I_KEY_PRI,
    input  logic                     O_READY,
    input  logic                     O_WAIT,
    input  logic                     O_ACK,
    input  logic                     O_SINGLE_HIT,
    input  logic                     O_MULTI_HIT,
    input  logic                     O_ENT_ERR,
    input  logic                     O_CMD_FULL,
    input  logic [VAL_W-1:0]         O_KEY_VALUE,
    input  logic [ADDR_W-1:0]        O_ENT_ADDR
);

    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_t         state_reg, state_next;
    logic               clear_pending_reg, clear_pending_next;
    logic               seen_low_reg;
    logic [1:0]         ones_cnt_reg;
    logic [TAG_W-1:0]   ptr_reg;

    logic [2:0]         cmd_arr [NUM_REQ];
    logic [KEY_W-1:0]   key_arr [NUM_REQ];
    logic [VAL_W-1:0]   val_arr [NUM_REQ];

    logic               grant_allowed;
    logic               grant_any;
    logic [TAG_W-1:0]   grant_idx;
    logic [5:0]         sel_strobes;
    logic               issue_valid;

    logic [TAG_W-1:0]   fifo_tag;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic               fifo_full;
    logic               ack_ok;

    logic [5:0]         strobe_reg;
    logic [KEY_W-1:0]   key_dat_reg;
    logic [VAL_W-1:0]   key_val_reg;
    logic               init_reg;
    logic               ready_reg;
    logic               error_reg;
    logic [NUM_REQ-1:0] rsp_valid_reg;
    logic               rsp_hit_reg;
    logic               rsp_multi_reg;
    logic               rsp_err_reg;
    logic [VAL_W-1:0]   rsp_value_reg;
    logic [ADDR_W-1:0]  rsp_addr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign cmd_arr[gi] = req_cmd[gi*3 +: 3];
            assign key_arr[gi] = req_key[gi*KEY_W +: KEY_W];
            assign val_arr[gi] = req_value[gi*VAL_W +: VAL_W];
        end
    endgenerate

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(MAX_OUTSTANDING));
    assign ack_ok     = O_ACK && !fifo_empty;

    // The incoming clear pulse blocks grants in its own cycle as well.
    assign grant_allowed = (state_reg == ST_RUN) && !O_WAIT && !O_CMD_FULL &&
                           !fifo_full && !clear_pending_reg && !clear;

    always_comb begin
        int idx;
        logic [TAG_W-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        idx       = 0;
        cand      = '0;
        if (grant_allowed) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = int'(ptr_reg) + i;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                cand = TAG_W'(idx);
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
            if (grant_any) req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_strobes = grant_any ? cmd_strobes(cmd_arr[grant_idx]) : 6'b000000;
    assign issue_valid = sel_strobes[5];

    always_comb begin
        state_next         = state_reg;
        clear_pending_next = clear_pending_reg | clear;
        case (state_reg)
            ST_WAIT_RDY:  if (O_READY) state_next = ST_INIT;
            ST_INIT:      state_next = ST_INIT_WAIT;
            ST_INIT_WAIT: if (O_READY && (seen_low_reg || ones_cnt_reg == 2'd3))
                              state_next = ST_RUN;
            ST_RUN:       if (clear_pending_reg || clear) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_next         = ST_INIT;
                    clear_pending_next = clear;
                end
            end
            default:      state_next = ST_WAIT_RDY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= ST_WAIT_RDY;
            clear_pending_reg <= 1'b0;
            seen_low_reg      <= 1'b0;
            ones_cnt_reg      <= '0;
            ptr_reg           <= '0;
            strobe_reg        <= '0;
            key_dat_reg       <= '0;
            key_val_reg       <= '0;
            init_reg          <= 1'b0;
            ready_reg         <= 1'b0;
            error_reg         <= 1'b0;
            rsp_valid_reg     <= '0;
            rsp_hit_reg       <= 1'b0;
            rsp_multi_reg     <= 1'b0;
            rsp_err_reg       <= 1'b0;
            rsp_value_reg     <= '0;
            rsp_addr_reg      <= '0;
        end else begin
            state_reg         <= state_next;
            clear_pending_reg <= clear_pending_next;
            init_reg          <= (state_next == ST_INIT);
            ready_reg         <= (state_next == ST_RUN);

            // O_READY bookkeeping only counts cycles spent in INIT_WAIT.
            if (state_reg == ST_INIT) begin
                seen_low_reg <= 1'b0;
                ones_cnt_reg <= '0;
            end else if (state_reg == ST_INIT_WAIT) begin
                if (!O_READY) begin
                    seen_low_reg <= 1'b1;
                    ones_cnt_reg <= '0;
                end else if (ones_cnt_reg != 2'd3) begin
                    ones_cnt_reg <= ones_cnt_reg + 1'b1;
                end
            end

            strobe_reg <= sel_strobes;
            if (grant_any) begin
                key_dat_reg <= key_arr[grant_idx];
                key_val_reg <= val_arr[grant_idx];
                ptr_reg     <= (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end

            rsp_valid_reg <= '0;
            if (ack_ok) begin
                rsp_valid_reg[fifo_tag] <= 1'b1;
                rsp_hit_reg             <= O_SINGLE_HIT | O_MULTI_HIT;
                rsp_multi_reg           <= O_MULTI_HIT;
                rsp_err_reg             <= O_ENT_ERR;
                rsp_value_reg           <= O_KEY_VALUE;
                rsp_addr_reg            <= O_ENT_ADDR;
            end
            if (O_ACK && fifo_empty) error_reg <= 1'b1;
        end
    end

    kvs_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .TAG_W (TAG_W)
    ) u_tag_fifo (
        .clk      (clk),
        .srst     (reset),
        .push     (issue_valid),
        .push_tag (grant_idx),
        .pop      (O_ACK),
        .pop_tag  (fifo_tag),
        .count    (fifo_count)
    );

    assign {I_CMD_VALID, I_CMD_SEARCH, I_CMD_UPDATE,
            I_CMD_WRITE, I_CMD_ERASE, I_CMD_READ} = strobe_reg;
    assign I_CMD_INIT  = init_reg;
    assign I_KEY_DAT   = key_dat_reg;
    assign I_KEY_VALUE = key_val_reg;
    assign I_EKEY_MSK  = '0;
    assign I_KEY_PRI   = '0;
    assign ready       = ready_reg;
    assign error       = error_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_hit     = rsp_hit_reg;
    assign rsp_multi   = rsp_multi_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_value   = rsp_value_reg;
    assign rsp_addr    = rsp_addr_reg;

endmodule

// File: doc/kvs_cmd_arbiter.md
# kvs_cmd_arbiter

Shares the single command/response port of `axonerve_kvs_kernel` between `NUM_REQ` requesters, for example the word-count search/add engine and a table readout engine. It sequences kernel initialisation after reset or on request, then arbitrates round-robin among requesters. Each issued command's requester index is kept in an order FIFO so that every `O_ACK` response is routed back to the requester that issued the command. The block sits directly between the requester engines and the kernel instance.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `MAX_OUTSTANDING`, 16: maximum number of commands in flight between issue and `O_ACK` (power of two).
- `clk` in 1: single clock.
- `reset` in 1: reset, synchronous and active-high.
- `clear` in 1: one-cycle pulse that requests kernel re-initialisation.
- `ready` out 1: high in RUN state only.
- `error` out 1: sticky; set when an `O_ACK` arrives with no command outstanding. Cleared by `reset`.
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_ready` out NUM_REQ: one-hot grant.
- `req_cmd` in NUM_REQ*3: per-requester `kvs_cmd_t` command.
- `req_key` in NUM_REQ*128: per-requester key.
- `req_value` in NUM_REQ*32: per-requester value.
- `rsp_valid` out NUM_REQ: one-hot response strobe.
- `rsp_hit` out 1: `O_SINGLE_HIT | O_MULTI_HIT`.
- `rsp_multi` out 1: `O_MULTI_HIT`.
- `rsp_err` out 1: `O_ENT_ERR`.
- `rsp_value` out 32: `O_KEY_VALUE`.
- `rsp_addr` out 16: `O_ENT_ADDR`.
- `I_CMD_INIT`, `I_CMD_VALID`, `I_CMD_ERASE`, `I_CMD_WRITE`, `I_CMD_READ`, `I_CMD_SEARCH`, `I_CMD_UPDATE` out 1 each: kernel command strobes.
- `I_KEY_DAT` out 128 and `I_KEY_VALUE` out 32: kernel command data.
- `I_EKEY_MSK` out 128 and `I_KEY_PRI` out 7: driven constant 0.
- `O_READY`, `O_WAIT`, `O_ACK`, `O_SINGLE_HIT`, `O_MULTI_HIT`, `O_ENT_ERR`, `O_CMD_FULL` in 1 each: kernel status and response.
- `O_KEY_VALUE` in 32 and `O_ENT_ADDR` in 16: kernel response data.

## Operation
- **States:** WAIT_RDY, INIT, INIT_WAIT, RUN, DRAIN.
- **Reset:** state goes to WAIT_RDY. All outputs reset to 0: every `I_*` output, `req_ready`, `rsp_*`, `ready` and `error`. The round-robin pointer resets to 0 and the outstanding count resets to 0.
- **WAIT_RDY:** wait for `O_READY`=1, then go to INIT.
- **INIT:** drive `I_CMD_INIT`=1 for exactly one cycle, then go to INIT_WAIT.
- **INIT_WAIT:** leave when `O_READY` has been seen 0 and then 1 again, or after 4 consecutive cycles of `O_READY`=1. Go to RUN.
- **RUN, grant condition:** grant when `O_WAIT`=0, `O_CMD_FULL`=0, outstanding < `MAX_OUTSTANDING`, no `clear` pending, and at least one `req_valid` bit is set.
- **RUN, grant selection:** the grant goes to the first valid requester at or after the pointer, wrapping. The pointer then moves to the granted index + 1, modulo `NUM_REQ`.
- **RUN, handshake:** `req_ready` is combinational. The transfer completes when `req_valid & req_ready`. Requesters hold `req_cmd`, `req_key` and `req_value` stable until granted.
- **Command decode:**
  - CMD_SEARCH drives `I_CMD_SEARCH`.
  - CMD_UPDATE drives `I_CMD_UPDATE`.
  - CMD_WRITE drives `I_CMD_WRITE`.
  - CMD_ERASE drives `I_CMD_ERASE`.
  - CMD_READ drives `I_CMD_READ`.
  - Any other code is accepted but issued with `I_CMD_VALID`=0. It is not counted as outstanding and receives no response.
- **Issue:** each accepted command pushes its requester index into the tag FIFO and increments the outstanding count.
- **Responses:**
  - On `O_ACK`, pop the tag FIFO, decrement the outstanding count, and strobe `rsp_valid[tag]`.
  - An issue and an ack in the same cycle leave the outstanding count unchanged.
  - `O_ACK` with an empty FIFO is dropped and sets `error`.
- **`clear`:**
  - A pulse is latched as pending. New grants stop.
  - RUN moves to DRAIN, which waits for outstanding = 0 and then goes to INIT.
  - `clear` outside RUN is latched and serviced on the next entry to RUN.
- **Reset mid-operation:** all in-flight tags are discarded. Responses arriving after reset set `error`.

## Timing
- **Issue latency:** grant at cycle t drives the `I_CMD_*` strobes at cycle t+1, held for one cycle. `I_KEY_DAT` and `I_KEY_VALUE` are registered at t+1.
- **Response latency:** `O_ACK` at cycle a drives `rsp_valid` and `rsp_*` at cycle a+1, one cycle wide, registered.
- **Throughput:** one command per cycle while all grant conditions hold.
- **`O_WAIT`/`O_CMD_FULL`:** these are sampled combinationally into the grant. The grant condition above is the only backpressure.
- **Tag FIFO:** cannot overflow, because depth = `MAX_OUTSTANDING`.

## Structure
- **Package `kvs_pkg`:**
  - `kvs_cmd_t` (3-bit): CMD_NOP=0, CMD_SEARCH=1, CMD_UPDATE=2, CMD_WRITE=3, CMD_ERASE=4, CMD_READ=5.
  - Width constants: KEY_W=128, VAL_W=32, ADDR_W=16.
  - Arbiter state enum.
- **Sub-module `kvs_tag_fifo`:** synchronous FIFO holding $clog2(`NUM_REQ`)-bit tags, depth `MAX_OUTSTANDING`, with a count output.

## Test plan
- **Reset/init:** `O_READY` held 0 for 10 cycles then raised → exactly one `I_CMD_INIT` pulse; `ready`=1 after INIT_WAIT exits.
- **Round-robin:** both requesters hold `req_valid` for 6 cycles → grants alternate 0,1,0,1,0,1. `I_KEY_DAT` matches the granted key one cycle after each grant.
- **Response routing:** requester 1 issues SEARCH key 0xA5.., then requester 0 issues UPDATE. The kernel model acks in order with `O_ENT_ADDR`=0x0012 then 0x0034 → `rsp_valid[1]` with `rsp_addr`=0x0012 first, then `rsp_valid[0]` with 0x0034.
- **Backpressure:** stall acks until 16 commands are outstanding → `req_ready`=0 at 16. `O_WAIT`=1 → no grant. One ack → one new grant.
- **Clear with traffic:** `clear` pulse with 3 commands outstanding → no new grants. After 3 acks, one `I_CMD_INIT` pulse, then RUN resumes.
- **Spurious ack:** `O_ACK` with nothing outstanding → `error`=1 stays set, no `rsp_valid`; `reset` clears `error`.
